// File: rtl/led_div_writer.sv
// Divider write-side driver for the LED counter: sweeps div_o between DIV_MIN and DIV_MAX
// (ramp or triangle) at a programmable interval, with host overrides taking priority.
module led_div_writer #(
  parameter int unsigned      DIV_W   = 12,
  parameter logic [DIV_W-1:0] DIV_MIN = DIV_W'(1),
  parameter logic [DIV_W-1:0] DIV_MAX = DIV_W'(4095),
  parameter int unsigned      STEP    = 1,
  parameter int unsigned      HOLD_W  = 24
) (
  input  logic              clk100,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              mode_i,
  input  logic [HOLD_W-1:0] hold_i,
  input  logic [DIV_W-1:0]  host_div_i,
  input  logic              host_wr_i,
  output logic [DIV_W-1:0]  div_o,
  output logic              wren_o,
  output logic              dir_o,
  output logic              run_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  localparam logic [DIV_W:0]   StepX       = (DIV_W+1)'(STEP);
  localparam logic [DIV_W-1:0] StepN       = DIV_W'(STEP);
  localparam logic [DIV_W:0]   MinX        = {1'b0, DIV_MIN};
  localparam logic [DIV_W:0]   MaxX        = {1'b0, DIV_MAX};
  localparam logic [DIV_W:0]   MinPlusStep = MinX + StepX;

  logic [0:0]        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              wren_q, wren_d;
  logic              dir_q, dir_d;

  logic [HOLD_W-1:0] hold_eff;
  logic              running;
  logic              fire;
  logic [DIV_W:0]    up;
  logic [DIV_W-1:0]  dn;
  logic [DIV_W-1:0]  step_div;
  logic              step_dir;
  logic [DIV_W-1:0]  host_clamped;

  // Step arithmetic: candidate next value and direction for the current mode.
  always_comb begin
    hold_eff = (hold_i == '0) ? HOLD_W'(1) : hold_i;
    running  = (state_q == StRun) && en_i;
    fire     = running && (cnt_q >= hold_eff - HOLD_W'(1));
    up       = {1'b0, div_q} + StepX;
    dn       = div_q - StepN;
    step_div = up[DIV_W-1:0];
    step_dir = 1'b0;
    if (!mode_i) begin
      step_dir = 1'b0;
      step_div = (up > MaxX) ? DIV_MIN : up[DIV_W-1:0];
    end else if (!dir_q) begin
      if (up > MaxX) begin
        step_dir = 1'b1;
        step_div = dn;
      end else begin
        step_dir = 1'b0;
        step_div = up[DIV_W-1:0];
      end
    end else begin
      if ({1'b0, div_q} < MinPlusStep) begin
        step_dir = 1'b0;
        step_div = up[DIV_W-1:0];
      end else begin
        step_dir = 1'b1;
        step_div = dn;
      end
    end
  end

  always_comb begin
    if (host_div_i < DIV_MIN) begin
      host_clamped = DIV_MIN;
    end else if (host_div_i > DIV_MAX) begin
      host_clamped = DIV_MAX;
    end else begin
      host_clamped = host_div_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en_i)  state_d = StRun;
      StRun:   if (!en_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    cnt_d = '0;
    if (running && !fire) begin
      cnt_d = cnt_q + HOLD_W'(1);
    end

    div_d  = div_q;
    dir_d  = dir_q;
    wren_d = 1'b0;
    // A host write swallows a coincident step so only one strobe is issued.
    if (host_wr_i) begin
      div_d  = host_clamped;
      wren_d = 1'b1;
      cnt_d  = '0;
    end else if (fire) begin
      div_d  = step_div;
      dir_d  = step_dir;
      wren_d = 1'b1;
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= DIV_MIN;
      wren_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      wren_q  <= wren_d;
      dir_q   <= dir_d;
    end
  end

  assign div_o  = div_q;
  assign wren_o = wren_q;
  assign dir_o  = dir_q;
  assign run_o  = (state_q == StRun);

endmodule
